// File: rtl/adc_envelope_detector_if.sv
// Streaming bus between the ADC front end and the envelope detector.
// With ADC_ENV_CLIP_DETECT_EN defined the bus also carries the rail-hit flag clip_o.
`default_nettype none

interface adc_envelope_detector_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  mode_i;
  logic                  env_clr_i;
  logic                  out_valid_o;
  logic [DATA_WIDTH-2:0] mag_out_o;
  logic [DATA_WIDTH-2:0] env_out_o;
`ifdef ADC_ENV_CLIP_DETECT_EN
  logic                  clip_o;
`endif

  modport master (
    output in_valid_i, in_data_i, mode_i, env_clr_i,
`ifdef ADC_ENV_CLIP_DETECT_EN
    input  clip_o,
`endif
    input  out_valid_o, mag_out_o, env_out_o
  );

  modport slave (
    input  in_valid_i, in_data_i, mode_i, env_clr_i,
`ifdef ADC_ENV_CLIP_DETECT_EN
    output clip_o,
`endif
    output out_valid_o, mag_out_o, env_out_o
  );
endinterface

`default_nettype wire

// File: rtl/adc_envelope_detector.sv
// Two-stage ADC rectifier (half/full wave) with peak envelope: instant attack, hold, exponential decay.
// Optional rail-hit flag on the bus when ADC_ENV_CLIP_DETECT_EN is defined.
`default_nettype none

module adc_envelope_detector #(
  parameter int DATA_WIDTH   = 12,
  parameter int DECAY_SHIFT  = 4,
  parameter int HOLD_SAMPLES = 2,
  parameter int HOLD_BITS    = 8
) (
  input wire logic               clk,
  input wire logic               rst,
  adc_envelope_detector_if.slave bus
);
  localparam int MW = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH:0] C_MID     = {2'b01, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [MW-1:0]       C_MAG_MAX = '1;
  localparam logic [MW-1:0]       C_ONE     = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [HOLD_BITS-1:0] C_HOLD   = HOLD_BITS'(HOLD_SAMPLES);
  localparam logic [HOLD_BITS-1:0] C_HOLD_DEC = HOLD_BITS'(1);

  logic signed [DATA_WIDTH:0] diff_w;
  logic [DATA_WIDTH:0]        abs_w;
  logic [MW-1:0]              mag_w;

  logic                 s1_valid_q;
  logic [MW-1:0]        s1_mag_q;
  logic                 out_valid_q;
  logic [MW-1:0]        mag_q;
  logic [MW-1:0]        env_q, env_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [MW-1:0]        step_w;

  // Offset-binary to signed, rectify, then clip the single full-scale negative code.
  always_comb begin
    diff_w = $signed({1'b0, bus.in_data_i} - C_MID);
    abs_w  = '0;
    if (diff_w[DATA_WIDTH]) begin
      if (bus.mode_i) abs_w = -diff_w;
    end else begin
      abs_w = diff_w;
    end
    mag_w = (abs_w > {2'b00, C_MAG_MAX}) ? C_MAG_MAX : abs_w[MW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.env_clr_i) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
    end else begin
      s1_valid_q <= bus.in_valid_i;
      if (bus.in_valid_i) s1_mag_q <= mag_w;
    end
  end

  always_comb begin
    env_d  = env_q;
    hold_d = hold_q;
    step_w = env_q >> DECAY_SHIFT;
    if (step_w == '0) step_w = C_ONE;
    if (s1_valid_q) begin
      if (s1_mag_q >= env_q) begin
        env_d  = s1_mag_q;
        hold_d = C_HOLD;
      end else if (hold_q != '0) begin
        hold_d = hold_q - C_HOLD_DEC;
      end else begin
        env_d = (env_q >= step_w) ? env_q - step_w : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      env_q       <= '0;
      hold_q      <= '0;
    end else if (bus.env_clr_i) begin
      out_valid_q <= 1'b0;
      env_q       <= '0;
      hold_q      <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      env_q       <= env_d;
      hold_q      <= hold_d;
      if (s1_valid_q) mag_q <= s1_mag_q;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.mag_out_o   = mag_q;
  assign bus.env_out_o   = env_q;

`ifdef ADC_ENV_CLIP_DETECT_EN
  logic s1_clip_q;
  logic clip_q;

  always_ff @(posedge clk) begin
    if (rst || bus.env_clr_i) begin
      s1_clip_q <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      if (bus.in_valid_i) s1_clip_q <= (bus.in_data_i == '0) || (bus.in_data_i == '1);
      clip_q <= s1_valid_q & s1_clip_q;
    end
  end

  assign bus.clip_o = clip_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_adc_envelope_detector.sv
// Self-checking bench: queue-based envelope model plus hand-computed literal sequences.
`default_nettype none

module tb_adc_envelope_detector;
  localparam int W    = 12;
  localparam int DS   = 4;
  localparam int HOLD = 2;
  localparam int HALF = 1 << (W - 1);
  localparam int FULL = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_envelope_detector_if #(.DATA_WIDTH(W)) bus ();

  adc_envelope_detector #(
    .DATA_WIDTH(W), .DECAY_SHIFT(DS), .HOLD_SAMPLES(HOLD), .HOLD_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int rect(int data, bit full);
    int d;
    int m;
    d = data - HALF;
    if (full) m = (d < 0) ? -d : d;
    else      m = (d > 0) ? d : 0;
    return (m > HALF - 1) ? HALF - 1 : m;
  endfunction

  // Reference: accepted samples wait in a queue until their due cycle, then update the envelope.
  typedef struct {int mag; int clip; int due;} item_t;
  item_t pend[$];
  item_t it;
  int cyc = 0, m_env = 0, m_hold = 0, step = 0;
  int e_valid = 0, e_mag = 0, e_env = 0, e_clip = 0;
  bit m_ready = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst || bus.env_clr_i) begin
      pend.delete();
      m_env = 0; m_hold = 0;
      e_valid = 0; e_env = 0; e_clip = 0;
      if (rst) begin e_mag = 0; m_ready = 1; end
    end else begin
      e_valid = 0; e_clip = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        it = pend.pop_front();
        if (it.mag >= m_env) begin
          m_env = it.mag; m_hold = HOLD;
        end else if (m_hold > 0) begin
          m_hold--;
        end else begin
          step = m_env >> DS;
          if (step < 1) step = 1;
          m_env = (m_env - step < 0) ? 0 : m_env - step;
        end
        e_valid = 1; e_mag = it.mag; e_clip = it.clip; e_env = m_env;
      end
      if (bus.in_valid_i)
        pend.push_back('{rect(int'(bus.in_data_i), bus.mode_i),
                         int'(bus.in_data_i == 0 || int'(bus.in_data_i) == FULL), cyc + 1});
    end
  end

  always @(negedge clk) begin
    if (m_ready && !rst) begin
      check("model_out_valid", int'(bus.out_valid_o), e_valid);
      check("model_env_out", int'(bus.env_out_o), e_env);
      if (e_valid != 0) check("model_mag_out", int'(bus.mag_out_o), e_mag);
`ifdef ADC_ENV_CLIP_DETECT_EN
      check("model_clip", int'(bus.clip_o), e_clip);
`endif
    end
  end

  // One isolated sample: checks the 2-clock latency and the literal mag/env results.
  task automatic lit(int data, bit md, int xm, int xe, string tag);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1; bus.in_data_i = W'(data); bus.mode_i = md;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, int'(bus.out_valid_o), 0);
    @(negedge clk);
    check({tag, "_valid"}, int'(bus.out_valid_o), 1);
    check({tag, "_mag"}, int'(bus.mag_out_o), xm);
    check({tag, "_env"}, int'(bus.env_out_o), xe);
  endtask

  task automatic clear();
    @(posedge clk); #1 bus.env_clr_i = 1'b1;
    @(posedge clk); #1 bus.env_clr_i = 1'b0;
  endtask

  int r;

  initial begin
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.mode_i = 1'b0; bus.env_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(bus.out_valid_o), 0);
    check("reset_mag", int'(bus.mag_out_o), 0);
    check("reset_env", int'(bus.env_out_o), 0);

    // half-wave
    lit(3000, 0, 952, 952, "hw0");
    lit(1000, 0, 0, 952, "hw1");
    lit(2048, 0, 0, 952, "hw2");

    // full-wave including the saturating code
    clear();
    lit(1000, 1, 1048, 1048, "fw0");
    lit(0,    1, 2047, 2047, "fw1");
    lit(4095, 1, 2047, 2047, "fw2");

    // hold then decay
    clear();
    lit(3048, 1, 1000, 1000, "hd0");
    lit(2048, 1, 0, 1000, "hd1");
    lit(2048, 1, 0, 1000, "hd2");
    lit(2048, 1, 0, 938, "hd3");
    lit(2048, 1, 0, 880, "hd4");

    // minimum decay step of 1 down to the floor
    clear();
    lit(2058, 1, 10, 10, "md_load");
    for (int i = 0; i < 14; i++)
      lit(2048, 1, 0, (i < 2) ? 10 : ((10 - (i - 1) > 0) ? 10 - (i - 1) : 0), "md_step");

`ifdef ADC_ENV_CLIP_DETECT_EN
    clear();
    lit(0, 1, 2047, 2047, "clip0");    check("clip_low", int'(bus.clip_o), 1);
    lit(4095, 1, 2047, 2047, "clip1"); check("clip_high", int'(bus.clip_o), 1);
    lit(2000, 1, 48, 2047, "clip2");   check("clip_none", int'(bus.clip_o), 0);
`endif

    // env_clr with two samples in flight
    @(posedge clk); #1 bus.in_valid_i = 1'b1; bus.in_data_i = W'(3000); bus.mode_i = 1'b0;
    @(posedge clk); #1 bus.in_data_i = W'(1000);
    @(posedge clk); #1 bus.in_data_i = W'(3500); bus.env_clr_i = 1'b1;
    @(posedge clk); #1 bus.in_valid_i = 1'b0; bus.env_clr_i = 1'b0;
    @(negedge clk);
    check("clr_valid0", int'(bus.out_valid_o), 0);
    check("clr_env0", int'(bus.env_out_o), 0);
    @(negedge clk);
    check("clr_valid1", int'(bus.out_valid_o), 0);
    check("clr_env1", int'(bus.env_out_o), 0);

    // reset mid-stream
    @(posedge clk); #1 bus.in_valid_i = 1'b1; bus.in_data_i = W'(3900); bus.mode_i = 1'b1;
    @(posedge clk); #1 bus.in_data_i = W'(100);
    @(posedge clk); #1 bus.in_data_i = W'(2500);
    @(posedge clk); #1 rst = 1'b1; bus.in_valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", int'(bus.out_valid_o), 0);
    check("rst_mid_mag", int'(bus.mag_out_o), 0);
    check("rst_mid_env", int'(bus.env_out_o), 0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      r = int'($urandom_range(0, 9));
      bus.in_valid_i = ($urandom_range(0, 9) < 7);
      bus.in_data_i  = (r == 0) ? W'(0) : (r == 1) ? W'(FULL) :
                       (r < 5) ? W'(HALF - 20 + int'($urandom_range(0, 40))) : W'($urandom);
      if ($urandom_range(0, 49) == 0) bus.mode_i = ~bus.mode_i;
      bus.env_clr_i  = ($urandom_range(0, 99) < 2);
      rst            = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.env_clr_i = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
